// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, drives the byte address to instruction memory and latches the returned word into IF/ID.
// Latency: the PC shown on imem_addr in cycle n appears in if_id_* in cycle n+1. A redirect costs one bubble.
// Backpressure: stall holds the PC and IF/ID. A redirect overrides stall. A fault halts fetch until reset.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          IMEM_WORDS   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        valid_nxt;
  logic [31:0] id_pc_nxt, id_pc4_nxt, id_instr_nxt;
  logic        fault_nxt;
  logic [31:0] count_nxt;
  logic        pc_out_of_range;

  // The memory address comes only from the PC register, so no input reaches an output combinationally.
  assign imem_addr       = pc;
  assign pc_out_of_range = ({2'b00, pc[31:2]} >= IMEM_LIMIT);

  // Register update: a synchronous reset restores every output to its idle value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= RUN;
      pc             <= RESET_VECTOR;
      if_id_valid    <= 1'b0;
      if_id_pc       <= 32'h0;
      if_id_pc_plus4 <= 32'h0;
      if_id_instr    <= NOP_INSTR;
      fetch_fault    <= 1'b0;
      fetch_count    <= 32'h0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      if_id_valid    <= valid_nxt;
      if_id_pc       <= id_pc_nxt;
      if_id_pc_plus4 <= id_pc4_nxt;
      if_id_instr    <= id_instr_nxt;
      fetch_fault    <= fault_nxt;
      fetch_count    <= count_nxt;
    end
  end

  // Next-state logic. In RUN the checks are ordered: misaligned redirect, redirect, stall, range check, then fetch.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    valid_nxt    = if_id_valid;
    id_pc_nxt    = if_id_pc;
    id_pc4_nxt   = if_id_pc_plus4;
    id_instr_nxt = if_id_instr;
    fault_nxt    = fetch_fault;
    count_nxt    = fetch_count;
    case (state)
      RUN: begin
        if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
          // A misaligned target can never be fetched, so halt and leave the PC unchanged.
          state_nxt = HALT;
          fault_nxt = 1'b1;
          valid_nxt = 1'b0;
        end else if (redirect_valid) begin
          // Flush the wrong-path instruction. Decode stalling does not block the flush.
          pc_nxt    = redirect_target;
          valid_nxt = 1'b0;
        end else if (stall) begin
          // Hold the PC and the IF/ID register until decode is ready.
        end else if (pc_out_of_range) begin
          state_nxt = HALT;
          fault_nxt = 1'b1;
          valid_nxt = 1'b0;
        end else begin
          id_pc_nxt    = pc;
          id_pc4_nxt   = pc + 32'd4;
          id_instr_nxt = imem_instr;
          valid_nxt    = 1'b1;
          pc_nxt       = pc + 32'd4;
          count_nxt    = fetch_count + 32'd1;
        end
      end
      HALT: begin
        valid_nxt = 1'b0;
        fault_nxt = 1'b1;
      end
      default: begin
        state_nxt = HALT;
        valid_nxt = 1'b0;
        fault_nxt = 1'b1;
      end
    endcase
  end

endmodule
